ixc_ififo_unpack: RTL and testbench

Packet unpacker directly downstream of the input FIFO. Accepts 512-bit words carrying 1–8 valid 64-bit lanes and stages them in a 16-lane circular buffer. Parses a 64-bit header per packet, strips pad lanes, and emits header plus payload one lane per cycle with start, end and transaction-ID sideband. Returns consumed-lane acknowledgements (`ackClkX`/`ackLenX`) so the FIFO can free space.

---
 rtl/ixc_ififo_pkg.sv | 19 +
 rtl/ixc_ififo_unpack_if.sv | 34 +++
 rtl/ixc_ififo_lanebuf.sv | 70 +++++++
 rtl/ixc_ififo_unpack.sv | 140 ++++++++++++++
 tb/tb_ixc_ififo_unpack.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ixc_ififo_pkg.sv
// ixc_ififo_pkg: shared constants and types for the input-FIFO unpacker.
// Header field offsets, pad value, header check magic, lane width, FSM states.
package ixc_ififo_pkg;

    localparam int LANE_W       = 64;
    localparam int HDR_FLD_W    = 16;
    localparam int HDR_TID_LSB  = 0;
    localparam int HDR_PKTL_LSB = 16;
    localparam int HDR_CHK_LSB  = 32;

    localparam logic [LANE_W-1:0]    PAD_LANE  = '0;
    localparam logic [HDR_FLD_W-1:0] HDR_MAGIC = 16'hC0DE;

    typedef enum logic {
        HDR,
        PAY
    } state_t;

endpackage

// File: rtl/ixc_ififo_unpack_if.sv
// ixc_ififo_unpack_if: input word bus, output lane bus, ack and error sideband.
// master = producer/consumer side, slave = unpacker side.
interface ixc_ififo_unpack_if #(
    parameter int LANES_MAX = 8
);
    import ixc_ififo_pkg::*;

    logic                        oDataEn;
    logic [LANES_MAX*LANE_W-1:0] oData;
    logic [3:0]                  oDataLen;
    logic                        iReady;
    logic [LANE_W-1:0]           laneOut;
    logic                        laneValid;
    logic                        laneReady;
    logic                        laneSop;
    logic                        laneEop;
    logic [15:0]                 laneTid;
    logic                        ackClkX;
    logic [17:0]                 ackLenX;
    logic                        hdrErr;

    modport master (
        output oDataEn, oData, oDataLen, laneReady,
        input  iReady, laneOut, laneValid, laneSop, laneEop,
        input  laneTid, ackClkX, ackLenX, hdrErr
    );

    modport slave (
        input  oDataEn, oData, oDataLen, laneReady,
        output iReady, laneOut, laneValid, laneSop, laneEop,
        output laneTid, ackClkX, ackLenX, hdrErr
    );

endinterface

// File: rtl/ixc_ififo_lanebuf.sv
// ixc_ififo_lanebuf: circular lane buffer, multi-lane write, single-lane pop.
// Ports: i_wr_en/i_wr_data/i_wr_len write, i_pop pop, o_head, o_empty, o_ready.
module ixc_ififo_lanebuf
    import ixc_ififo_pkg::*;
#(
    parameter int LANES_MAX = 8,
    parameter int BUF_LANES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_wr_en,
    input  logic [LANES_MAX*LANE_W-1:0] i_wr_data,
    input  logic [3:0]                  i_wr_len,
    input  logic                        i_pop,
    output logic [LANE_W-1:0]           o_head,
    output logic                        o_empty,
    output logic                        o_ready
);

    localparam int PW = $clog2(BUF_LANES);
    localparam int OW = PW + 1;

    logic [LANE_W-1:0] r_mem [BUF_LANES];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [OW-1:0]     r_occ;
    logic              r_ready;
    logic [OW-1:0]     w_acc;
    logic [OW-1:0]     w_occ_nxt;
    logic              w_pop;

    // Oversized lengths are clamped to a full word.
    always_comb begin
        w_acc = '0;
        if (i_wr_en && r_ready) begin
            if (32'(i_wr_len) > LANES_MAX) w_acc = OW'(LANES_MAX);
            else                           w_acc = OW'(i_wr_len);
        end
    end

    assign w_pop     = i_pop && (r_occ != '0);
    assign w_occ_nxt = r_occ + w_acc - OW'(w_pop);

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES_MAX; k++) begin
            if (OW'(k) < w_acc)
                r_mem[r_wptr + PW'(k)] <= i_wr_data[k*LANE_W +: LANE_W];
        end
    end

    // Ready looks at next occupancy so a full word always fits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_ready <= 1'b1;
        end else begin
            r_wptr  <= r_wptr + PW'(w_acc);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_occ   <= w_occ_nxt;
            r_ready <= (w_occ_nxt <= OW'(LANES_MAX));
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_occ == '0);
    assign o_ready = r_ready;

endmodule

// File: rtl/ixc_ififo_unpack.sv
// ixc_ififo_unpack: parses headers, drops pads, emits lanes with sop/eop/tid, acks.
// Ports: clk, reset (sync high), bus (slave). Option: IXC_IFIFO_UNPACK_HDR_CHK_EN.
module ixc_ififo_unpack
    import ixc_ififo_pkg::*;
#(
    parameter int LANES_MAX = 8,
    parameter int BUF_LANES = 16
) (
    input  logic               clk,
    input  logic               reset,
    ixc_ififo_unpack_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_remain;
    logic [15:0]       r_tid;
    logic [17:0]       r_pend;
    logic              r_ack;
    logic [17:0]       r_ack_len;
    logic [LANE_W-1:0] w_head;
    logic              w_empty;
    logic              w_pop;
    logic              w_valid;
    logic              w_sop;
    logic              w_eop;
    logic              w_hs;
    logic              w_pad;
    logic              w_bad;
    logic [15:0]       w_pktl;
    logic [15:0]       w_tid;

    ixc_ififo_lanebuf #(
        .LANES_MAX (LANES_MAX),
        .BUF_LANES (BUF_LANES)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (bus.oDataEn),
        .i_wr_data (bus.oData),
        .i_wr_len  (bus.oDataLen),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_empty   (w_empty),
        .o_ready   (bus.iReady)
    );

    assign w_pktl = w_head[HDR_PKTL_LSB +: HDR_FLD_W];
    assign w_tid  = w_head[HDR_TID_LSB +: HDR_FLD_W];
    assign w_pad  = (w_head == PAD_LANE);

`ifdef IXC_IFIFO_UNPACK_HDR_CHK_EN
    logic r_err;

    assign w_bad = !w_pad
                && (w_head[HDR_CHK_LSB +: HDR_FLD_W] != HDR_MAGIC);

    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else if (r_state == HDR && !w_empty && w_bad) r_err <= 1'b1;
    end

    assign bus.hdrErr = r_err;
`else
    assign w_bad      = 1'b0;
    assign bus.hdrErr = 1'b0;
`endif

    // Pads and rejected headers are popped silently while in HDR.
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_sop       = 1'b0;
        w_eop       = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            HDR: begin
                if (!w_empty) begin
                    if (w_pad || w_bad) begin
                        w_pop = 1'b1;
                    end else begin
                        w_valid = 1'b1;
                        w_sop   = 1'b1;
                        w_eop   = (w_pktl == 16'd0);
                        w_pop   = bus.laneReady;
                        if (bus.laneReady && !w_eop) w_state_nxt = PAY;
                    end
                end
            end
            PAY: begin
                if (!w_empty) begin
                    w_valid = 1'b1;
                    w_eop   = (r_remain == 16'd1);
                    w_pop   = bus.laneReady;
                    if (bus.laneReady && w_eop) w_state_nxt = HDR;
                end
            end
            default: ;
        endcase
    end

    assign w_hs = w_valid && bus.laneReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= HDR;
            r_remain  <= '0;
            r_tid     <= '0;
            r_pend    <= '0;
            r_ack     <= 1'b0;
            r_ack_len <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_hs && w_eop;
            if (w_hs && w_sop) begin
                r_tid    <= w_tid;
                r_remain <= w_pktl;
            end else if (w_hs) begin
                r_remain <= r_remain - 16'd1;
            end
            // Pending counts every popped lane; EOP folds it into an ack.
            if (w_hs && w_eop) begin
                r_pend    <= '0;
                r_ack_len <= r_pend + 18'd1;
            end else if (w_pop) begin
                r_pend <= r_pend + 18'd1;
            end
        end
    end

    // Header tid shows before it is latched so sop lanes carry their own id.
    assign bus.laneOut   = w_valid ? w_head : '0;
    assign bus.laneValid = w_valid;
    assign bus.laneSop   = w_sop;
    assign bus.laneEop   = w_eop;
    assign bus.laneTid   = (r_state == HDR && w_valid) ? w_tid : r_tid;
    assign bus.ackClkX   = r_ack;
    assign bus.ackLenX   = r_ack_len;

endmodule

// File: tb/tb_ixc_ififo_unpack.sv
// tb_ixc_ififo_unpack: scoreboard bench for the unpacker.
// Packet-level model feeds expected lane/ack queues; a monitor checks them.
module tb_ixc_ififo_unpack;

    typedef struct {
        logic [63:0] d;
        bit          sop;
        bit          eop;
        logic [15:0] tid;
    } exp_t;

    logic clk;
    logic reset;

    ixc_ififo_unpack_if bus ();

    ixc_ififo_unpack dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          ack_q[$];
    logic [63:0] stream[$];
    int          pending;
    int          n_chk;
    int          n_fail;
    int          n_hs;
    int          rdy_mode;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Packet-level model: pads, header, payload; ack = lanes since last EOP.
    task automatic add_pads(input int n);
        for (int i = 0; i < n; i++) stream.push_back(64'd0);
        pending += n;
    endtask

    task automatic add_packet(input int npad, input logic [15:0] tid,
                              input int pktl);
        logic [63:0] h;
        logic [63:0] p;
        exp_t        e;
        add_pads(npad);
        h = {16'($urandom), 16'hC0DE, 16'(pktl), tid};
        stream.push_back(h);
        e.d = h; e.sop = 1; e.eop = (pktl == 0); e.tid = tid;
        exp_q.push_back(e);
        for (int i = 0; i < pktl; i++) begin
            p = {$urandom, $urandom};
            stream.push_back(p);
            e.d = p; e.sop = 0; e.eop = (i == pktl - 1); e.tid = tid;
            exp_q.push_back(e);
        end
        ack_q.push_back(pending + 1 + pktl);
        pending = 0;
    endtask

    // fixed=0 picks random word sizes, idles, no-op and oversized lengths.
    task automatic send(input int fixed, input int max_lanes);
        int sent;
        int to;
        sent = 0;
        to   = 0;
        while (stream.size() > 0 && sent < max_lanes) begin
            int          avail;
            int          len;
            logic [3:0]  lf;
            logic        en;
            logic [511:0] d;
            @(negedge clk);
            avail = stream.size();
            if (max_lanes - sent < avail) avail = max_lanes - sent;
            len = (fixed != 0) ? fixed : $urandom_range(0, 8);
            if (len > avail) len = avail;
            lf = 4'(len);
            if (fixed == 0 && len == 8 && $urandom_range(0, 2) == 0)
                lf = 4'($urandom_range(9, 15));
            en = (fixed != 0) || ($urandom_range(0, 4) != 0);
            for (int k = 0; k < 8; k++)
                d[k*64 +: 64] = (k < len) ? stream[k] : {$urandom, $urandom};
            bus.oDataEn  = en;
            bus.oData    = d;
            bus.oDataLen = lf;
            if (en && bus.iReady) begin
                for (int k = 0; k < len; k++) void'(stream.pop_front());
                sent += len;
                to = 0;
            end else begin
                to++;
                if (to > 500) begin
                    n_chk++; n_fail++;
                    $display("FAIL send_timeout actual=stalled required=iReady");
                    break;
                end
            end
        end
        @(negedge clk);
        bus.oDataEn  = 1'b0;
        bus.oDataLen = 4'd0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(exp_q.size() + ack_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iReady"},    64'(bus.iReady),    64'd1);
        chk({tag, "_laneValid"}, 64'(bus.laneValid), 64'd0);
        chk({tag, "_laneSop"},   64'(bus.laneSop),   64'd0);
        chk({tag, "_laneEop"},   64'(bus.laneEop),   64'd0);
        chk({tag, "_ackClkX"},   64'(bus.ackClkX),   64'd0);
        chk({tag, "_hdrErr"},    64'(bus.hdrErr),    64'd0);
        chk({tag, "_laneOut"},   bus.laneOut,        64'd0);
        chk({tag, "_laneTid"},   64'(bus.laneTid),   64'd0);
        chk({tag, "_ackLenX"},   64'(bus.ackLenX),   64'd0);
    endtask

    initial begin
        bus.laneReady = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: bus.laneReady = 1'b1;
                1: bus.laneReady = ($urandom_range(0, 2) != 0);
                2: bus.laneReady = 1'b0;
                default: ;
            endcase
        end
    end

    // Monitor: samples just before each rising edge.
    initial begin
        logic        prev_stall;
        logic [63:0] prev_out;
        logic [15:0] prev_tid;
        exp_t        e;
        prev_stall = 1'b0;
        prev_out   = '0;
        prev_tid   = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.laneValid), 64'd1);
                    chk("stall_out", bus.laneOut, prev_out);
                    chk("stall_tid", 64'(bus.laneTid), 64'(prev_tid));
                end
                if (bus.laneValid && bus.laneReady) begin
                    n_hs++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_lane", bus.laneOut, 64'hx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("lane_data", bus.laneOut, e.d);
                        chk("lane_sop", 64'(bus.laneSop), 64'(e.sop));
                        chk("lane_eop", 64'(bus.laneEop), 64'(e.eop));
                        chk("lane_tid", 64'(bus.laneTid), 64'(e.tid));
                    end
                end
                if (bus.ackClkX) begin
                    if (ack_q.size() == 0)
                        chk("unexpected_ack", 64'(bus.ackLenX), 64'hx);
                    else
                        chk("ack_len", 64'(bus.ackLenX), 64'(ack_q.pop_front()));
                end
                prev_stall = bus.laneValid && !bus.laneReady;
                prev_out   = bus.laneOut;
                prev_tid   = bus.laneTid;
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        n_chk = 0; n_fail = 0; n_hs = 0; pending = 0; rdy_mode = 0;
        reset = 1'b1;
        bus.oDataEn = 1'b0; bus.oData = '0; bus.oDataLen = 4'd0;
        repeat (3) @(negedge clk);
        #4 chk_reset_vals("rst_init");
        @(negedge clk);
        reset = 1'b0;
        #4 chk_reset_vals("rst_idle");

        // Single packet with exact timing.
        add_packet(0, 16'h0012, 2);
        send(3, 1000);
        #4;
        chk("t1_c1_valid", 64'(bus.laneValid), 64'd1);
        chk("t1_c1_sop", 64'(bus.laneSop), 64'd1);
        chk("t1_c1_tid", 64'(bus.laneTid), 64'h12);
        @(negedge clk); #4;
        chk("t1_c2_valid", 64'(bus.laneValid), 64'd1);
        chk("t1_c2_eop", 64'(bus.laneEop), 64'd0);
        @(negedge clk); #4;
        chk("t1_c3_eop", 64'(bus.laneEop), 64'd1);
        @(negedge clk); #4;
        chk("t1_ack", 64'(bus.ackClkX), 64'd1);
        chk("t1_ack_len", 64'(bus.ackLenX), 64'd3);
        drain();

        // Pads around a header-only packet; trailing pad stays pending.
        add_packet(2, 16'h0034, 0);
        add_pads(1);
        send(4, 1000);
        drain();

        // Stalled fills across the pointer wrap.
        for (int r = 0; r < 3; r++) begin
            rdy_mode = 2;
            @(negedge clk);
            add_packet(0, 16'(16'h100 + r), (r == 1) ? 9 : 8);
            send((r == 2) ? 4 : 5, 1000);
            #4 chk("wrap_iReady_low", 64'(bus.iReady), 64'd0);
            rdy_mode = 0;
            drain();
        end

        // Random backpressure on a long packet.
        rdy_mode = 1;
        add_packet(0, 16'h0BB0, 20);
        send(0, 1000);
        drain();
        rdy_mode = 0;

        // Reset after 5 of 21 lanes.
        rdy_mode = 2;
        @(negedge clk);
        add_packet(0, 16'h0C0C, 20);
        send(8, 16);
        @(negedge clk);
        rdy_mode = 3;
        bus.laneReady = 1'b1;
        hs0 = n_hs;
        repeat (5) @(negedge clk);
        bus.laneReady = 1'b0;
        reset = 1'b1;
        exp_q.delete(); ack_q.delete(); stream.delete();
        pending = 0;
        chk("rst_mid_lanes", 64'(n_hs - hs0), 64'd5);
        @(negedge clk); #4;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        rdy_mode = 0;
        repeat (4) begin
            @(negedge clk); #4;
            chk("rst_no_ack", 64'(bus.ackClkX), 64'd0);
        end
        add_packet(1, 16'h0D0D, 3);
        send(0, 1000);
        drain();

        // Random mix, including back-to-back header-only packets.
        rdy_mode = 1;
        for (int i = 0; i < 30; i++)
            add_packet($urandom_range(0, 2), 16'($urandom),
                       ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6));
        add_pads($urandom_range(0, 2));
        send(0, 100000);
        drain();
        rdy_mode = 0;

`ifdef IXC_IFIFO_UNPACK_HDR_CHK_EN
        stream.push_back({16'h1234, 16'hBEEF, 16'd3, 16'h0E0E});
        pending += 1;
        add_packet(0, 16'h0F0F, 2);
        send(0, 1000);
        drain();
        chk("hdr_err_set", 64'(bus.hdrErr), 64'd1);
`else
        chk("hdr_err_tied", 64'(bus.hdrErr), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
